// File: rtl/nv_glb_pkg.sv
// Shared definitions for the global interrupt controller: CSB register offsets,
// request/response layouts and response type encodings.
package nv_glb_pkg;

  localparam logic [21:0] OFF_STATUS  = 22'h00;
  localparam logic [21:0] OFF_MASK    = 22'h01;
  localparam logic [21:0] OFF_SWSET   = 22'h02;
  localparam logic [21:0] OFF_VERSION = 22'h03;
  localparam logic [21:0] OFF_EVCNT   = 22'h10;

  typedef enum logic {
    RESP_READ  = 1'b0,
    RESP_WRITE = 1'b1
  } resp_type_e;

  // 63-bit CSB request, MSB first.
  typedef struct packed {
    logic [6:0]  rsvd;
    logic        nposted;
    logic        write;
    logic [31:0] wdat;
    logic [21:0] addr;
  } req_t;

  // 34-bit CSB response, MSB first.
  typedef struct packed {
    resp_type_e  typ;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

endpackage

// File: rtl/nv_glb_sat_cnt.sv
// Purpose: saturating event counter with synchronous clear.
// Latency: count visible the cycle after inc; clear+inc together lands on 1.
// Backpressure: none, updates every cycle.
module nv_glb_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= CNT_W'(inc);
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/nv_glb_intr_ctrl.sv
// Purpose: latches unit done pulses into W1C status, masks them into core_intr, counts events.
// Latency: CSB response 1 cycle after accept; core_intr 1 cycle after STATUS changes.
// Backpressure: always ready out of reset; responses cannot be stalled.
module nv_glb_intr_ctrl
  import nv_glb_pkg::*;
#(
  parameter int          NUM_SRC   = 6,
  parameter int          CNT_W     = 8,
  parameter logic [21:0] BASE_ADDR = 22'h0,
  parameter logic [31:0] HW_VER    = 32'h1
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rst,
  input  logic                   csb2glb_req_pvld,
  output logic                   csb2glb_req_prdy,
  input  logic [62:0]            csb2glb_req_pd,
  output logic                   glb2csb_resp_valid,
  output logic [33:0]            glb2csb_resp_pd,
  input  logic [2*NUM_SRC-1:0]   done_intr_pd,
  output logic                   core_intr
);

  localparam int NB = 2 * NUM_SRC;

  req_t              req;
  resp_t             resp;
  logic              accept;
  logic              wr_acc;
  logic [21:0]       offset;
  logic [21:0]       ev_idx;
  logic              hit_evcnt;
  logic [NB-1:0]     status;
  logic [NB-1:0]     mask;
  logic [NB-1:0]     swset;
  logic [NB-1:0]     w1c;
  logic [NB-1:0]     ev_clr;
  logic [CNT_W-1:0]  evcnt [NB];
  logic [31:0]       rd_data;
  logic              rd_err;
  logic              resp_vld_q;
  logic              unused_req_bits;

  assign req       = req_t'(csb2glb_req_pd);
  assign accept    = csb2glb_req_pvld & csb2glb_req_prdy;
  assign wr_acc    = accept & req.write;
  assign offset    = req.addr - BASE_ADDR;
  assign ev_idx    = offset - OFF_EVCNT;
  assign hit_evcnt = (offset >= OFF_EVCNT) && (ev_idx < 22'(NB));
  assign w1c       = (wr_acc && (offset == OFF_STATUS)) ? req.wdat[NB-1:0] : '0;
  assign unused_req_bits = ^{req.rsvd, req.wdat};

  for (genvar k = 0; k < NB; k++) begin : g_cnt
    assign ev_clr[k] = wr_acc && hit_evcnt && (ev_idx == 22'(k));
    nv_glb_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk (nvdla_core_clk),
      .rst (nvdla_core_rst),
      .inc (done_intr_pd[k]),
      .clr (ev_clr[k]),
      .cnt (evcnt[k])
    );
  end

  // Read mux looks at pre-update register values.
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (offset == OFF_STATUS) begin
      rd_data = 32'(status);
    end else if (offset == OFF_MASK) begin
      rd_data = 32'(mask);
    end else if (offset == OFF_SWSET) begin
      rd_data = 32'(swset);
    end else if (offset == OFF_VERSION) begin
      rd_data = HW_VER;
    end else if (hit_evcnt) begin
      for (int k = 0; k < NB; k++) begin
        if (ev_idx == 22'(k)) rd_data = 32'(evcnt[k]);
      end
    end else begin
      rd_err = 1'b1;
    end
  end

  always_comb begin
    resp       = '0;
    resp.typ   = req.write ? RESP_WRITE : RESP_READ;
    resp.err   = rd_err;
    resp.rdata = req.write ? 32'h0 : rd_data;
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      csb2glb_req_prdy <= 1'b0;
      resp_vld_q       <= 1'b0;
      glb2csb_resp_pd  <= '0;
      core_intr        <= 1'b0;
      status           <= '0;
      mask             <= '1;
      swset            <= '0;
    end else begin
      csb2glb_req_prdy <= 1'b1;
      resp_vld_q       <= accept & (~req.write | req.nposted);
      if (accept) glb2csb_resp_pd <= resp;
      // Hardware set beats a same-cycle W1C of the same bit.
      status    <= (status & ~w1c) | done_intr_pd | swset;
      core_intr <= |(status & ~mask);
      if (wr_acc && (offset == OFF_MASK))  mask  <= req.wdat[NB-1:0];
      if (wr_acc && (offset == OFF_SWSET)) swset <= req.wdat[NB-1:0];
    end
  end

  // A response due in the cycle reset is raised is dropped rather than issued.
  assign glb2csb_resp_valid = resp_vld_q & ~nvdla_core_rst;

endmodule

// File: tb/tb_nv_glb_intr_ctrl.sv
// Bench for nv_glb_intr_ctrl: cycle model of the 6-unit instance plus directed literal checks,
// and a 16-unit instance sharing the CSB bus for the top interrupt bit.
module tb_nv_glb_intr_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pvld = 1'b0;
  logic [62:0] req_pd = '0;
  logic [11:0] done = '0;
  logic [31:0] b_done = '0;

  logic        a_prdy, a_vld, a_intr;
  logic [33:0] a_pd;
  logic        b_prdy, b_vld, b_intr;
  logic [33:0] b_pd;

  logic        cap_a_vld, cap_b_vld;
  logic [33:0] cap_a_pd, cap_b_pd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nv_glb_intr_ctrl #(.NUM_SRC(6), .CNT_W(8), .BASE_ADDR(22'h0), .HW_VER(32'h1)) u_dut (
    .nvdla_core_clk     (clk),
    .nvdla_core_rst     (rst),
    .csb2glb_req_pvld   (pvld),
    .csb2glb_req_prdy   (a_prdy),
    .csb2glb_req_pd     (req_pd),
    .glb2csb_resp_valid (a_vld),
    .glb2csb_resp_pd    (a_pd),
    .done_intr_pd       (done),
    .core_intr          (a_intr)
  );

  nv_glb_intr_ctrl #(.NUM_SRC(16), .CNT_W(8), .BASE_ADDR(22'h0), .HW_VER(32'h1)) u_dut16 (
    .nvdla_core_clk     (clk),
    .nvdla_core_rst     (rst),
    .csb2glb_req_pvld   (pvld),
    .csb2glb_req_prdy   (b_prdy),
    .csb2glb_req_pd     (req_pd),
    .glb2csb_resp_valid (b_vld),
    .glb2csb_resp_pd    (b_pd),
    .done_intr_pd       (b_done),
    .core_intr          (b_intr)
  );

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the 6-unit instance ----------------
  logic        m_live = 1'b0;
  logic        m_prdy, m_vld, m_core;
  logic [33:0] m_pd;
  logic [11:0] m_status, m_mask, m_swset;
  int          m_cnt [12];
  int          m_off;
  logic        m_acc, m_wr, m_np, m_err;
  logic [31:0] m_wd, m_rd;

  always @(posedge clk) begin
    if (rst) begin
      m_live = 1'b1; m_prdy = 1'b0; m_vld = 1'b0; m_pd = '0; m_core = 1'b0;
      m_status = '0; m_mask = '1; m_swset = '0;
      for (int k = 0; k < 12; k++) m_cnt[k] = 0;
    end else if (m_live) begin
      m_core = |(m_status & ~m_mask);
      m_acc  = pvld && m_prdy;
      m_off  = int'(req_pd[21:0]);
      m_wd   = req_pd[53:22];
      m_wr   = req_pd[54];
      m_np   = req_pd[55];
      m_rd   = 32'h0;
      m_err  = 1'b0;
      if      (m_off == 0) m_rd = {20'h0, m_status};
      else if (m_off == 1) m_rd = {20'h0, m_mask};
      else if (m_off == 2) m_rd = {20'h0, m_swset};
      else if (m_off == 3) m_rd = 32'h1;
      else if (m_off >= 16 && m_off < 28) m_rd = 32'(m_cnt[m_off-16]);
      else m_err = 1'b1;
      m_vld = m_acc && (!m_wr || m_np);
      if (m_acc) m_pd = {m_wr, m_err, (m_wr ? 32'h0 : m_rd)};
      m_status = (m_status & ~((m_acc && m_wr && m_off == 0) ? m_wd[11:0] : 12'h0)) | done | m_swset;
      for (int k = 0; k < 12; k++) begin
        if (m_acc && m_wr && m_off == 16 + k) m_cnt[k] = int'(done[k]);
        else if (done[k] && m_cnt[k] < 255) m_cnt[k] = m_cnt[k] + 1;
      end
      if (m_acc && m_wr && m_off == 1) m_mask  = m_wd[11:0];
      if (m_acc && m_wr && m_off == 2) m_swset = m_wd[11:0];
      m_prdy = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("prdy", 34'(a_prdy), 34'(m_prdy));
      check("resp_valid", 34'(a_vld), 34'(m_vld && !rst));
      if (m_vld && !rst) check("resp_pd", a_pd, m_pd);
      check("core_intr", 34'(a_intr), 34'(m_core));
    end
  end

  // ---------------- stimulus helpers (inputs change 2 time units after posedge) ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic csb(input logic wr, input logic np, input logic [21:0] addr, input logic [31:0] wdat);
    req_pd = {7'h0, np, wr, wdat, addr};
    pvld   = 1'b1;
    tick();
    pvld      = 1'b0;
    cap_a_vld = a_vld;
    cap_a_pd  = a_pd;
    cap_b_vld = b_vld;
    cap_b_pd  = b_pd;
  endtask

  task automatic rd_chk(input string name, input logic [21:0] addr, input logic [31:0] rdata, input logic err);
    csb(1'b0, 1'b0, addr, 32'h0);
    check({name, "_vld"}, 34'(cap_a_vld), 34'd1);
    check(name, cap_a_pd, {1'b0, err, rdata});
  endtask

  task automatic b_rd_chk(input string name, input logic [21:0] addr, input logic [31:0] rdata);
    csb(1'b0, 1'b0, addr, 32'h0);
    check({name, "_vld"}, 34'(cap_b_vld), 34'd1);
    check(name, cap_b_pd, {2'b00, rdata});
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state and MASK read
    check("rst_core_intr", 34'(a_intr), 34'd0);
    rd_chk("t1_mask", 22'h01, 32'h0000_0FFF, 1'b0);

    // Unmask, done bit 3, then W1C with ack
    csb(1'b1, 1'b0, 22'h01, 32'h0);
    check("t2_posted_silent", 34'(cap_a_vld), 34'd0);
    tick();
    done = 12'h008;
    tick();
    done = 12'h000;
    check("t2_core_lag", 34'(a_intr), 34'd0);
    tick();
    check("t2_core_set", 34'(a_intr), 34'd1);
    rd_chk("t2_status", 22'h00, 32'h0000_0008, 1'b0);
    csb(1'b1, 1'b1, 22'h00, 32'h0000_0008);
    check("t2_ack_vld", 34'(cap_a_vld), 34'd1);
    check("t2_ack_pd", cap_a_pd, 34'h2_0000_0000);
    check("t2_core_hold", 34'(a_intr), 34'd1);
    tick();
    check("t2_core_fall", 34'(a_intr), 34'd0);

    // Set beats same-cycle W1C
    done = 12'h020;
    csb(1'b1, 1'b0, 22'h00, 32'h0000_0020);
    done = 12'h000;
    rd_chk("t3_status", 22'h00, 32'h0000_0020, 1'b0);
    rd_chk("t3_evcnt5", 22'h15, 32'h1, 1'b0);

    // Counter saturation and clear
    done = 12'h001;
    repeat (300) tick();
    done = 12'h000;
    rd_chk("t4_evcnt0_sat", 22'h10, 32'd255, 1'b0);
    csb(1'b1, 1'b0, 22'h10, 32'h0);
    rd_chk("t4_evcnt0_clr", 22'h10, 32'd0, 1'b0);
    done = 12'h001;
    csb(1'b1, 1'b0, 22'h10, 32'h0);
    done = 12'h000;
    rd_chk("t4_clr_and_inc", 22'h10, 32'd1, 1'b0);

    // Unmapped offsets, VERSION, SWSET
    rd_chk("t5_bad_rd", 22'h07, 32'h0, 1'b1);
    csb(1'b1, 1'b0, 22'h07, 32'hFFFF_FFFF);
    check("t5_bad_wr_silent", 34'(cap_a_vld), 34'd0);
    csb(1'b1, 1'b1, 22'h07, 32'hFFFF_FFFF);
    check("t5_bad_wr_ack", cap_a_pd, 34'h3_0000_0000);
    rd_chk("t5_mask_kept", 22'h01, 32'h0, 1'b0);
    rd_chk("t5_status_kept", 22'h00, 32'h0000_0021, 1'b0);
    csb(1'b1, 1'b1, 22'h03, 32'h55);
    check("t5_ver_wr_ack", cap_a_pd, 34'h2_0000_0000);
    rd_chk("t5_version", 22'h03, 32'h1, 1'b0);
    csb(1'b1, 1'b0, 22'h02, 32'h400);
    csb(1'b1, 1'b0, 22'h02, 32'h0);
    rd_chk("t5_swset_status", 22'h00, 32'h0000_0421, 1'b0);
    csb(1'b1, 1'b0, 22'h00, 32'h0000_0421);
    rd_chk("t5_status_clr", 22'h00, 32'h0, 1'b0);

    // Reset while a response is in flight
    req_pd = {7'h0, 1'b0, 1'b0, 32'h0, 22'h01};
    pvld   = 1'b1;
    tick();
    pvld = 1'b0;
    rst  = 1'b1;
    #3;
    check("t6_resp_dropped", 34'(a_vld), 34'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("t6_no_late_resp", 34'(a_vld), 34'd0);
    rd_chk("t6_mask", 22'h01, 32'h0000_0FFF, 1'b0);
    rd_chk("t6_status", 22'h00, 32'h0, 1'b0);
    rd_chk("t6_swset", 22'h02, 32'h0, 1'b0);
    rd_chk("t6_evcnt0", 22'h10, 32'h0, 1'b0);
    check("t6_core", 34'(a_intr), 34'd0);

    // 16-unit instance: bit 31
    csb(1'b1, 1'b0, 22'h01, 32'h0);
    b_done = 32'h8000_0000;
    tick();
    b_done = 32'h0;
    tick();
    check("b_core_set", 34'(b_intr), 34'd1);
    b_rd_chk("b_status31", 22'h00, 32'h8000_0000);
    b_rd_chk("b_evcnt31", 22'h2F, 32'h1);
    csb(1'b1, 1'b1, 22'h00, 32'h8000_0000);
    check("b_w1c_ack", cap_b_pd, 34'h2_0000_0000);
    b_rd_chk("b_status_clr", 22'h00, 32'h0);
    tick();
    check("b_core_clr", 34'(b_intr), 34'd0);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
